// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
// Module : pic_pkg
// Brief  : Shared widths and one-hot state codes for the PIC acknowledge path.
// Rev    : 1.0  initial release
// ============================================================================
package pic_pkg;

   localparam int LEVEL_W  = 3;
   localparam int VECTOR_W = 8;
   localparam int STATE_W  = 6;

   typedef logic [STATE_W-1:0] state_t;

   localparam state_t IDLE  = 6'b000001;
   localparam state_t PEND  = 6'b000010;
   localparam state_t ACK1  = 6'b000100;
   localparam state_t WAIT2 = 6'b001000;
   localparam state_t ACK2  = 6'b010000;
   localparam state_t DONE  = 6'b100000;

endpackage
`default_nettype wire

// File: rtl/inta_sync.sv
`default_nettype none
// ============================================================================
// Module : inta_sync
// Brief  : Active-low strobe synchroniser with registered rise/fall detection.
// Rev    : 1.0  initial release
// ============================================================================
module inta_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_pin_n,
   output logic o_fall,
   output logic o_rise
);

   logic [SYNC_STAGES-1:0] r_chain;
   logic                   r_prev;
   logic                   w_sync;

   assign w_sync = r_chain[SYNC_STAGES-1];

   // Chain and history reset to the inactive (high) level so release of
   // reset never manufactures an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_chain <= '1;
         r_prev  <= 1'b1;
         o_fall  <= 1'b0;
         o_rise  <= 1'b0;
      end else begin
         r_chain <= {r_chain[SYNC_STAGES-2:0], i_pin_n};
         r_prev  <= w_sync;
         o_fall  <= r_prev & ~w_sync;
         o_rise  <= ~r_prev & w_sync;
      end
   end

endmodule
`default_nettype wire

// File: rtl/inta_sequencer.sv
`default_nettype none
// ============================================================================
// Module : inta_sequencer
// Brief  : CPU interrupt-acknowledge handshake between resolver and 8086 bus.
// Rev    : 1.0  initial release
// ============================================================================
module inta_sequencer
   import pic_pkg::*;
#(
   parameter int                 SYNC_STAGES    = 2,
   parameter logic [LEVEL_W-1:0] SPURIOUS_LEVEL = 3'd7
) (
   input  logic                         CLK,
   input  logic                         RESET,
   input  logic                         INT_REQ,
   input  logic [LEVEL_W-1:0]           REQ_LEVEL,
   input  logic [VECTOR_W-LEVEL_W-1:0]  ICW2_T,
   input  logic                         AEOI_EN,
   input  logic                         INTA_N,
   output logic                         INT,
   output logic                         LATCH_ISR,
   output logic [LEVEL_W-1:0]           ACK_LEVEL,
   output logic [VECTOR_W-1:0]          DATA_OUT,
   output logic                         DATA_OE,
   output logic                         AEOI_PULSE,
   output logic                         BUSY
);

   state_t r_state;
   logic   r_spurious;
   logic   w_fall;
   logic   w_rise;

   inta_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_inta_sync (
      .clk     (CLK),
      .rst     (RESET),
      .i_pin_n (INTA_N),
      .o_fall  (w_fall),
      .o_rise  (w_rise)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state    <= IDLE;
         r_spurious <= 1'b0;
         INT        <= 1'b0;
         LATCH_ISR  <= 1'b0;
         ACK_LEVEL  <= '0;
         DATA_OUT   <= '0;
         DATA_OE    <= 1'b0;
         AEOI_PULSE <= 1'b0;
         BUSY       <= 1'b0;
      end else begin
         LATCH_ISR  <= 1'b0;
         AEOI_PULSE <= 1'b0;
         case (r_state)
            IDLE: begin
               if (INT_REQ) begin
                  r_state <= PEND;
                  INT     <= 1'b1;
                  BUSY    <= 1'b1;
               end
            end
            // INT is held even if the request vanishes; the CPU is owed an ack.
            PEND: begin
               if (w_fall) begin
                  r_state    <= ACK1;
                  INT        <= 1'b0;
                  LATCH_ISR  <= INT_REQ;
                  r_spurious <= ~INT_REQ;
                  ACK_LEVEL  <= INT_REQ ? REQ_LEVEL : SPURIOUS_LEVEL;
               end
            end
            ACK1: begin
               if (w_rise) begin
                  r_state <= WAIT2;
               end
            end
            WAIT2: begin
               if (w_fall) begin
                  r_state  <= ACK2;
                  DATA_OUT <= {ICW2_T, ACK_LEVEL};
               end
            end
            ACK2: begin
               if (w_rise) begin
                  r_state    <= DONE;
                  DATA_OE    <= 1'b0;
                  AEOI_PULSE <= AEOI_EN & ~r_spurious;
               end else begin
                  DATA_OE <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               BUSY    <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               INT     <= 1'b0;
               DATA_OE <= 1'b0;
               BUSY    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_inta_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_inta_sequencer
// Brief  : Self-checking bench for inta_sequencer against a handshake-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_inta_sequencer;

   logic       CLK;
   logic       RESET;
   logic       INT_REQ;
   logic [2:0] REQ_LEVEL;
   logic [4:0] ICW2_T;
   logic       AEOI_EN;
   logic       INTA_N;
   logic       INT;
   logic       LATCH_ISR;
   logic [2:0] ACK_LEVEL;
   logic [7:0] DATA_OUT;
   logic       DATA_OE;
   logic       AEOI_PULSE;
   logic       BUSY;

   int checks   = 0;
   int failures = 0;

   // Per-handshake event log gathered on the falling clock edge.
   int         latch_cnt = 0;
   int         oe_cnt    = 0;
   int         oe_bad    = 0;
   int         data_bad  = 0;
   int         aeoi_cnt  = 0;
   int         pulse_no  = 0;
   logic [2:0] latch_lvl = '0;
   logic [2:0] aeoi_lvl  = '0;
   logic [7:0] data_seen = '0;

   inta_sequencer #(
      .SYNC_STAGES    (2),
      .SPURIOUS_LEVEL (3'd7)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .INT_REQ    (INT_REQ),
      .REQ_LEVEL  (REQ_LEVEL),
      .ICW2_T     (ICW2_T),
      .AEOI_EN    (AEOI_EN),
      .INTA_N     (INTA_N),
      .INT        (INT),
      .LATCH_ISR  (LATCH_ISR),
      .ACK_LEVEL  (ACK_LEVEL),
      .DATA_OUT   (DATA_OUT),
      .DATA_OE    (DATA_OE),
      .AEOI_PULSE (AEOI_PULSE),
      .BUSY       (BUSY)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(negedge CLK) begin
      if (LATCH_ISR === 1'b1) begin
         latch_cnt++;
         latch_lvl = ACK_LEVEL;
      end
      if (DATA_OE === 1'b1) begin
         if (pulse_no != 2) oe_bad++;
         if (oe_cnt == 0) data_seen = DATA_OUT;
         else if (DATA_OUT !== data_seen) data_bad++;
         oe_cnt++;
      end
      if (AEOI_PULSE === 1'b1) begin
         aeoi_cnt++;
         aeoi_lvl = ACK_LEVEL;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full two-pulse acknowledge. Expectations come from the handshake
   // rules: level is the request level if a request was present at the
   // first acknowledge, else 7; vector is {T, level}; ISR latch and AEOI
   // only for a genuine request; data driven for w2-1 cycles.
   task automatic handshake(input logic spur, input logic [2:0] lvl, input logic [2:0] lvl_late,
                            input logic [4:0] t, input logic aeoi,
                            input int w1, input int w2, input int gap);
      logic [2:0] e_lvl;
      logic [7:0] e_vec;
      e_lvl = spur ? 3'd7 : lvl;
      e_vec = {t, e_lvl};

      ICW2_T    = t;
      AEOI_EN   = aeoi;
      REQ_LEVEL = lvl;
      INT_REQ   = 1'b1;
      step(1);
      chk("int_assert", 32'(INT), 1);
      chk("busy_pend", 32'(BUSY), 1);
      if (spur) begin
         step(2);
         INT_REQ = 1'b0;
         step(3);
         chk("int_hold_no_req", 32'(INT), 1);
      end

      latch_cnt = 0;
      oe_cnt    = 0;
      oe_bad    = 0;
      data_bad  = 0;
      aeoi_cnt  = 0;
      pulse_no  = 1;

      INTA_N = 1'b0;
      step(3);
      chk("int_before_strobe", 32'(INT), 1);
      step(1);
      chk("int_drop", 32'(INT), 0);
      step(w1 - 4);
      INTA_N = 1'b1;
      step(1);
      REQ_LEVEL = lvl_late;
      step(gap - 1);

      pulse_no = 2;
      INTA_N   = 1'b0;
      step(w2);
      INTA_N = 1'b1;
      step(4);
      chk("int_low_done", 32'(INT), 0);
      chk("oe_off_done", 32'(DATA_OE), 0);
      chk("aeoi_in_done", 32'(AEOI_PULSE), 32'(aeoi & ~spur));
      chk("ack_level_held", 32'(ACK_LEVEL), 32'(e_lvl));
      step(1);
      chk("busy_idle", 32'(BUSY), 0);
      chk("int_low_idle", 32'(INT), 0);

      chk("latch_count", 32'(latch_cnt), spur ? 0 : 1);
      if (!spur) chk("latch_level", 32'(latch_lvl), 32'(e_lvl));
      chk("oe_cycles", 32'(oe_cnt), 32'(w2 - 1));
      chk("vector", 32'(data_seen), 32'(e_vec));
      chk("vector_stable", 32'(data_bad), 0);
      chk("oe_first_pulse", 32'(oe_bad), 0);
      chk("aeoi_count", 32'(aeoi_cnt), (aeoi && !spur) ? 1 : 0);
      if (aeoi && !spur) chk("aeoi_level", 32'(aeoi_lvl), 32'(e_lvl));
   endtask

   initial begin
      logic spur_r;
      RESET     = 1'b1;
      INT_REQ   = 1'b0;
      REQ_LEVEL = 3'd0;
      ICW2_T    = 5'd0;
      AEOI_EN   = 1'b0;
      INTA_N    = 1'b1;
      step(1);
      chk("rst_int", 32'(INT), 0);
      chk("rst_latch", 32'(LATCH_ISR), 0);
      chk("rst_ack_level", 32'(ACK_LEVEL), 0);
      chk("rst_data_out", 32'(DATA_OUT), 0);
      chk("rst_data_oe", 32'(DATA_OE), 0);
      chk("rst_aeoi", 32'(AEOI_PULSE), 0);
      chk("rst_busy", 32'(BUSY), 0);
      step(1);
      RESET = 1'b0;
      step(2);
      chk("idle_no_req", 32'(INT), 0);

      // Normal, AEOI, spurious, level change, back-to-back levels 2 then 6.
      handshake(1'b0, 3'd3, 3'd3, 5'b01000, 1'b0, 6, 6, 3);
      handshake(1'b0, 3'd3, 3'd3, 5'b01000, 1'b1, 6, 6, 3);
      handshake(1'b1, 3'd3, 3'd4, 5'b01000, 1'b1, 6, 6, 3);
      handshake(1'b0, 3'd5, 3'd1, 5'b10110, 1'b0, 5, 6, 4);
      handshake(1'b0, 3'd2, 3'd6, 5'b00011, 1'b0, 6, 6, 3);
      handshake(1'b0, 3'd6, 3'd0, 5'b00011, 1'b1, 6, 6, 3);

      // Asynchronous reset while the vector is on the bus.
      INT_REQ   = 1'b0;
      step(1);
      ICW2_T    = 5'b11001;
      REQ_LEVEL = 3'd4;
      INT_REQ   = 1'b1;
      step(1);
      INTA_N = 1'b0;
      step(6);
      INTA_N = 1'b1;
      step(3);
      INTA_N = 1'b0;
      step(6);
      chk("oe_before_reset", 32'(DATA_OE), 1);
      #2;
      RESET = 1'b1;
      #1;
      chk("reset_async_oe", 32'(DATA_OE), 0);
      chk("reset_async_int", 32'(INT), 0);
      chk("reset_async_busy", 32'(BUSY), 0);
      step(1);
      chk("reset_no_latch", 32'(LATCH_ISR), 0);
      chk("reset_no_aeoi", 32'(AEOI_PULSE), 0);
      RESET  = 1'b0;
      INTA_N = 1'b1;
      step(1);
      chk("int_after_reset", 32'(INT), 1);
      INT_REQ = 1'b0;
      RESET   = 1'b1;
      step(1);
      RESET = 1'b0;
      step(1);

      for (int i = 0; i < 10; i++) begin
         spur_r = ($urandom_range(0, 3) == 0);
         handshake(spur_r, 3'($urandom), 3'($urandom), 5'($urandom), 1'($urandom),
                   $urandom_range(4, 8), $urandom_range(3, 8), $urandom_range(2, 6));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
